// File: rtl/tv_pkg.sv
// Shared types and default sizes for the test-vector recorder slice.
package tv_pkg;
    typedef enum logic [1:0] {TV_IDLE, TV_CAPTURE, TV_DUMP} tv_state_t;

    localparam int TV_WIDTH_DEF = 4;
    localparam int TV_DEPTH_DEF = 8;
endpackage

// File: rtl/tv_recorder_if.sv
// Sample/dump/status bundle of the recorder; the recorder is the slave, the host or logger the master.
interface tv_recorder_if import tv_pkg::*; #(
    parameter int WIDTH = TV_WIDTH_DEF,
    parameter int CNT_W = $clog2(TV_DEPTH_DEF) + 1
) ();
    logic             arm;
    logic             stop;
    logic             smp_valid;
    logic [WIDTH-1:0] smp_data;
    logic             dump_ready;
    logic             dump_valid;
    logic [WIDTH-1:0] dump_data;
    logic             dump_last;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             overflow;

    modport master (
        output arm, stop, smp_valid, smp_data, dump_ready,
        input  dump_valid, dump_data, dump_last, count, busy, overflow
    );

    modport slave (
        input  arm, stop, smp_valid, smp_data, dump_ready,
        output dump_valid, dump_data, dump_last, count, busy, overflow
    );
endinterface

// File: rtl/tv_buffer.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset on contents.
module tv_buffer import tv_pkg::*; #(
    parameter int WIDTH = TV_WIDTH_DEF,
    parameter int DEPTH = TV_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures sample words, then streams them out oldest first.
// Define TV_RECORDER_DEDUP_EN to skip samples equal to the previously written word.
module tv_recorder import tv_pkg::*; #(
    parameter int WIDTH = TV_WIDTH_DEF,
    parameter int DEPTH = TV_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    tv_recorder_if.slave bus
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    tv_state_t        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             we;
    logic             dup;
    logic             dump_valid;
    logic             dump_last;
    logic [WIDTH-1:0] rdata;

`ifdef TV_RECORDER_DEDUP_EN
    logic [WIDTH-1:0] last_q, last_d;

    // An empty session has no previous word, so its first sample is always kept.
    assign dup    = (count_q != '0) && (bus.smp_data == last_q);
    assign last_d = we ? bus.smp_data : last_q;

    always_ff @(posedge clk) begin
        last_q <= last_d;
    end
`else
    assign dup = 1'b0;
`endif

    assign dump_valid = (state_q == TV_DUMP);
    assign dump_last  = dump_valid && ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        case (state_q)
            TV_IDLE: begin
                if (bus.arm) begin
                    state_d    = TV_CAPTURE;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            TV_CAPTURE: begin
                if (bus.smp_valid && !dup) begin
                    if (count_q == FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        count_d  = count_q + CNT_W'(1);
                    end
                end
                // A stop that also writes a sample still has something to dump.
                if (count_q == FULL) begin
                    state_d = TV_DUMP;
                end else if (bus.stop) begin
                    state_d = (count_q == '0 && !we) ? TV_IDLE : TV_DUMP;
                end
            end
            TV_DUMP: begin
                if (bus.dump_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (dump_last) begin
                        state_d = TV_IDLE;
                    end
                end
            end
            default: state_d = TV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= TV_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    tv_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_buffer (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.smp_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.dump_valid = dump_valid;
    assign bus.dump_data  = dump_valid ? rdata : '0;
    assign bus.dump_last  = dump_last;
    assign bus.count      = count_q;
    assign bus.busy       = (state_q != TV_IDLE);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_tv_recorder.sv
// Scoreboard bench for tv_recorder: expected words queued at capture, popped at dump.
module tb_tv_recorder;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    tv_recorder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    tv_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic arm_session();
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL arm_state: busy=%b count=%0d overflow=%b dump_valid=%b, required busy=1 count=0 overflow=0 dump_valid=0",
                     bus.busy, bus.count, bus.overflow, bus.dump_valid);
        end
    endtask

    // Called at a negedge; the sample is taken at the following posedge.
    task automatic send(input logic [WIDTH-1:0] w, input bit expect_stored);
        bus.smp_valid = 1'b1;
        bus.smp_data  = w;
        if (expect_stored) sb.push_back(w);
        @(negedge clk);
        bus.smp_valid = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic check_count(input string tag, input logic [CNT_W-1:0] exp_cnt);
        checks++;
        if (bus.count !== exp_cnt) begin
            errors++;
            $display("FAIL %s: count=%0d, required %0d", tag, bus.count, exp_cnt);
        end
    endtask

    // Drains n words with a 16-cycle repeating ready pattern; span>0 demands that many cycles from first valid.
    task automatic drain(input string tag, input int n, input logic [15:0] pat, input bit finish, input int span);
        int xfers = 0;
        int i = 0;
        int first = -1;
        bit stalled = 1'b0;
        logic [WIDTH-1:0] held = '0;
        logic held_last = 1'b0;
        logic [WIDTH-1:0] exp_w;
        while (xfers < n && i < 200) begin
            bus.dump_ready = pat[i % 16];
            #1;
            if (bus.dump_valid === 1'b1) begin
                if (first < 0) first = i;
                if (stalled) begin
                    checks++;
                    if (bus.dump_data !== held || bus.dump_last !== held_last) begin
                        errors++;
                        $display("FAIL %s_stall_hold: data=%h last=%b, required data=%h last=%b",
                                 tag, bus.dump_data, bus.dump_last, held, held_last);
                    end
                end
                if (bus.dump_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s_extra_word: data=%h, required no transfer", tag, bus.dump_data);
                    end else begin
                        exp_w = sb.pop_front();
                        if (bus.dump_data !== exp_w) begin
                            errors++;
                            $display("FAIL %s_data: data=%h, required %h", tag, bus.dump_data, exp_w);
                        end
                        checks++;
                        if (bus.dump_last !== (sb.size() == 0)) begin
                            errors++;
                            $display("FAIL %s_last: dump_last=%b, required %b", tag, bus.dump_last, sb.size() == 0);
                        end
                    end
                    xfers++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = bus.dump_data;
                    held_last = bus.dump_last;
                end
            end
            i++;
            @(negedge clk);
        end
        checks++;
        if (xfers != n) begin
            errors++;
            $display("FAIL %s_transfers: got %0d transfers, required %0d", tag, xfers, n);
        end
        if (span > 0) begin
            checks++;
            if (i - first != span) begin
                errors++;
                $display("FAIL %s_span: dump took %0d cycles, required %0d", tag, i - first, span);
            end
        end
        bus.dump_ready = 1'b0;
        if (finish) begin
            #1;
            checks++;
            if (bus.dump_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_end: dump_valid=%b busy=%b, required 0 0", tag, bus.dump_valid, bus.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dump_valid !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.overflow !== 1'b0 ||
            bus.dump_last !== 1'b0 || bus.dump_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b count=%0d ovf=%b last=%b data=%h, required all 0",
                     bus.dump_valid, bus.busy, bus.count, bus.overflow, bus.dump_last, bus.dump_data);
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.dump_valid !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d valid=%b busy=%b count=%0d ovf=%b, required all 0",
                         k, bus.dump_valid, bus.busy, bus.count, bus.overflow);
            end
        end
    endtask

    task automatic test_full_dump();
        logic [WIDTH-1:0] words [8] = '{4'b0000, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100, 4'b1111};
        arm_session();
        for (int k = 0; k < 8; k++) send(words[k], 1'b1);
        check_count("full_count", 4'd8);
        drain("full", 8, 16'hFFFF, 1'b1, 8);
        check_count("full_count_retained", 4'd8);
    endtask

    task automatic test_early_stop();
        arm_session();
        send(4'b0011, 1'b1);
        send(4'b1100, 1'b1);
        pulse_stop();
        check_count("stop_count", 4'd2);
        drain("stop", 2, 16'hFFFF, 1'b1, 2);
        arm_session();
        pulse_stop();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_stop: cycle %0d busy=%b dump_valid=%b, required 0 0", k, bus.busy, bus.dump_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        arm_session();
        for (int k = 0; k < 8; k++) send(4'((k * 3) + 1), 1'b1);
        drain("bp", 8, 16'b1001_1001_1001_1001, 1'b1, 0);
    endtask

    task automatic test_overflow();
        arm_session();
        for (int k = 0; k < 9; k++) send(4'(k + 2), k < 8);
        check_count("ovf_count", 4'd8);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b, required 1", bus.overflow);
        end
        drain("ovf", 8, 16'hFFFF, 1'b1, 0);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%b, required 1", bus.overflow);
        end
    endtask

    task automatic test_reset_mid_dump();
        arm_session();
        for (int k = 0; k < 8; k++) send(4'(15 - k), 1'b1);
        drain("mid", 3, 16'hFFFF, 1'b0, 0);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dump_valid !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.dump_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_dump: valid=%b busy=%b count=%0d data=%h, required 0 0 0 0",
                     bus.dump_valid, bus.busy, bus.count, bus.dump_data);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
    endtask

`ifdef TV_RECORDER_DEDUP_EN
    task automatic test_dedup();
        arm_session();
        send(4'b0101, 1'b1);
        send(4'b0101, 1'b0);
        send(4'b0110, 1'b1);
        send(4'b0110, 1'b0);
        pulse_stop();
        check_count("dedup_count", 4'd2);
        drain("dedup", 2, 16'hFFFF, 1'b1, 2);
    endtask
`endif

    initial begin
        bus.arm        = 1'b0;
        bus.stop       = 1'b0;
        bus.smp_valid  = 1'b0;
        bus.smp_data   = '0;
        bus.dump_ready = 1'b0;
        rst            = 1'b0;
        test_reset();
        test_full_dump();
        test_early_stop();
        test_backpressure();
        test_overflow();
        test_reset_mid_dump();
`ifdef TV_RECORDER_DEDUP_EN
        test_dedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
